ser_arbiter: RTL and testbench
==============================

# ser_arbiter

Round-robin scheduler that shares one `serializer_in` datapath among `N` parallel-word requesters. It latches the winning requester's word and pulses the serializer's start, then waits for the serializer's end-of-frame strobe and returns a one-cycle acknowledge to the requester. A watchdog aborts a frame whose completion never arrives. The block sits between the requester ports and the serializer's `start_i`/`data_i` inputs.

## Interface
- `N`, default 4: number of requesters, minimum 2.
- `W`, default 8: word width; matches the serializer `data_i` width.
- `TIMEOUT`, default 64: maximum cycles spent in WAIT before abort, minimum 2.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_i` in N: per-requester request level; held until the matching `ack_o` bit.
- `data_i` in N*W: packed words; requester k uses bits [k*W +: W].
- `ack_o` out N: one-hot, one-cycle pulse; the frame for that requester is complete.
- `err_o` out 1: one-cycle pulse on watchdog abort.
- `grant_o` out N: one-hot index of the current owner; all zero when idle.
- `busy_o` out 1: high in every state except IDLE.
- `ser_start_o` out 1: one-cycle start pulse to the serializer.
- `ser_data_o` out W: latched word to the serializer; stable from START until the next grant.
- `ser_done_i` in 1: serializer end-of-frame strobe, one cycle.

## Operation
- FSM states:
  - IDLE: if any `req_i` bit is high, pick the winner, latch its word into `ser_data_o`, set `grant_o`, then go to START. Otherwise stay in IDLE.
  - START: `ser_start_o`=1, clear the watchdog counter, go to WAIT.
  - WAIT:
    - `ser_done_i`=1: go to ACK.
    - Else if counter == TIMEOUT-1: pulse `err_o`, clear `grant_o`, go to IDLE with no ack.
    - Else: increment the counter.
  - ACK: `ack_o[g]`=1, where g is the granted index. Go to IDLE and clear `grant_o`.
- Round-robin selection:
  - A `last` pointer holds the most recently served index.
  - The search order is last+1, last+2, …, wrapping modulo N.
  - `last` updates in ACK and on timeout, so an aborted requester drops to lowest priority.
- `ser_done_i` is ignored in IDLE, START and ACK.
- `data_i` and `req_i` of the granted requester are not re-sampled after the grant. A change in either has no effect until the next IDLE.
- A `req_i` bit falling while that requester is granted does not cancel the frame. The ack is still issued.
- The watchdog counter is $clog2(TIMEOUT) bits and never wraps.
- Reset, asynchronous:
  - State goes to IDLE.
  - All outputs are 0.
  - `last`=N-1, so requester 0 has first priority.
  - Counter is 0.
  - A frame in flight is abandoned with no ack and no err.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- Request to start: `req_i` sampled at edge e in IDLE → `grant_o` and `ser_data_o` valid, with `ser_start_o`=1, during cycle e+1.
- Done to ack: `ser_done_i` sampled at edge d in WAIT → `ack_o` high during cycle d+1 only.
- IDLE is re-entered at d+2. The requester must have dropped `req` by then, or the next level is treated as a new request.
- Minimum frame overhead is 4 cycles (IDLE, START, WAIT, ACK) plus the serializer's done latency.
- Timeout: `ser_done_i` never arrives → `err_o` pulses TIMEOUT cycles after START. IDLE follows on the next cycle.
- `ser_done_i` arriving in the same cycle as counter == TIMEOUT-1: done wins, giving ACK with no err.
- `busy_o` is high from cycle e+1 through the ACK cycle or the err cycle inclusive.

## Test plan
- Single requester, N=4, W=8: `req_i`=0001, word 8'hA5, done 9 cycles after start → `ser_start_o` 1-cycle pulse, `ser_data_o`=A5, `ack_o`=0001 one cycle after done, no `err_o`.
- All four requesting continuously from reset, distinct words 11/22/33/44 → grant order 0,1,2,3,0. Each `ser_data_o` matches its owner's word.
- No `ser_done_i`, TIMEOUT=64 → `err_o` pulse 64 cycles after START, no ack, `grant_o` cleared. Next grant skips the aborted index if others are requesting.
- `data_i` of the owner toggled and spurious `ser_done_i` driven during START → `ser_data_o` unchanged. The spurious done does not produce an ack; only a done in WAIT does.
- `rst_i` asserted mid-WAIT, asynchronously between edges → all outputs 0 immediately. After release, requester 0 wins first.
- Done coincident with counter == TIMEOUT-1 → ack issued, `err_o` stays 0.

Source files
------------

// File: rtl/ser_arbiter.sv
// Round-robin scheduler sharing one serializer among N parallel-word requesters.
// Latches the winner's word, pulses start, waits for done (with watchdog) and acks the owner.
module ser_arbiter #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [N-1:0]   req_i,
    input  logic [N*W-1:0] data_i,
    output logic [N-1:0]   ack_o,
    output logic           err_o,
    output logic [N-1:0]   grant_o,
    output logic           busy_o,
    output logic           ser_start_o,
    output logic [W-1:0]   ser_data_o,
    input  logic           ser_done_i
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    // S_ERR holds the one-cycle abort pulse so busy_o still covers it before IDLE.
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_ACK,
        S_ERR
    } state_t;

    state_t        state;
    logic [IW-1:0] last;
    logic [IW-1:0] owner;
    logic [IW-1:0] win_idx;
    logic [CW-1:0] cnt;
    logic [W-1:0]  words [N];

    for (genvar k = 0; k < N; k++) begin : g_words
        assign words[k] = data_i[k*W +: W];
    end

    // Search last+1, last+2, ... modulo N; the nearest requester after last wins.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] req, input logic [IW-1:0] from);
        logic [IW-1:0] pick;
        logic [IW-1:0] j;
        pick = from;
        for (int i = N; i >= 1; i--) begin
            j = IW'((int'(from) + i) % N);
            if (req[j]) pick = j;
        end
        return pick;
    endfunction

    assign win_idx = rr_pick(req_i, last);
    assign busy_o  = (state != S_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            last        <= IW'(N - 1);
            owner       <= '0;
            cnt         <= '0;
            ack_o       <= '0;
            err_o       <= 1'b0;
            grant_o     <= '0;
            ser_start_o <= 1'b0;
            ser_data_o  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req_i) begin
                        owner       <= win_idx;
                        grant_o     <= N'(1) << win_idx;
                        ser_data_o  <= words[win_idx];
                        ser_start_o <= 1'b1;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    ser_start_o <= 1'b0;
                    cnt         <= '0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    // done takes precedence over an expiring watchdog
                    if (ser_done_i) begin
                        ack_o <= grant_o;
                        last  <= owner;
                        state <= S_ACK;
                    end else if (cnt == CNT_LAST) begin
                        err_o   <= 1'b1;
                        grant_o <= '0;
                        last    <= owner;
                        state   <= S_ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    ack_o   <= '0;
                    grant_o <= '0;
                    state   <= S_IDLE;
                end
                S_ERR: begin
                    err_o <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ser_arbiter.sv
// Self-checking bench for ser_arbiter: scenario tasks with randomized frames
// checked against a round-robin reference kept as a plain integer pointer.
module tb_ser_arbiter;
    localparam int N       = 4;
    localparam int W       = 8;
    localparam int TIMEOUT = 64;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic [N-1:0]   req_i = '0;
    logic [N*W-1:0] data_i = '0;
    logic [N-1:0]   ack_o;
    logic           err_o;
    logic [N-1:0]   grant_o;
    logic           busy_o;
    logic           ser_start_o;
    logic [W-1:0]   ser_data_o;
    logic           ser_done_i = 1'b0;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int m_last    = N - 1;

    ser_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .data_i      (data_i),
        .ack_o       (ack_o),
        .err_o       (err_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .ser_start_o (ser_start_o),
        .ser_data_o  (ser_data_o),
        .ser_done_i  (ser_done_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d/%0d", pass_cnt, total_cnt);
        $fatal(1, "bench timeout");
    end

    function automatic int model_pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++)
            if (req[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic logic [2*N+2:0] ctl_obs();
        return {busy_o, ser_start_o, err_o, ack_o, grant_o};
    endfunction

    function automatic logic [2*N+2:0] ctl_exp(input logic busy, input logic start, input logic err,
                                               input logic [N-1:0] ack, input logic [N-1:0] grant);
        return {busy, start, err, ack, grant};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One complete frame: dly = cycles from start to done (1..TIMEOUT), anything else = never done.
    task automatic do_frame(input string tag, input logic [N-1:0] req, input logic [N*W-1:0] words,
                            input int dly, input bit spur, input bit drop);
        int w;
        logic [N-1:0] g;
        logic [W-1:0] wd;
        logic [2*N+2:0] e;
        bit to;
        w  = model_pick(req, m_last);
        g  = N'(1) << w;
        wd = words[w*W +: W];
        to = (dly < 1) || (dly > TIMEOUT);
        req_i = req; data_i = words; ser_done_i = 1'b0;
        step();
        e = ctl_exp(1'b1, 1'b1, 1'b0, '0, g);
        total_cnt++;
        if (ctl_obs() !== e) $display("FAIL %s start_ctl: got %b want %b", tag, ctl_obs(), e);
        else pass_cnt++;
        total_cnt++;
        if (ser_data_o !== wd) $display("FAIL %s start_data: got %h want %h", tag, ser_data_o, wd);
        else pass_cnt++;
        if (spur) begin ser_done_i = 1'b1; data_i = ~words; end
        if (drop) req_i = req & ~g;
        for (int j = 1; j <= (to ? TIMEOUT : dly); j++) begin
            step();
            ser_done_i = !to && (j == dly);
            e = ctl_exp(1'b1, 1'b0, 1'b0, '0, g);
            total_cnt++;
            if (ctl_obs() !== e) $display("FAIL %s wait_ctl[%0d]: got %b want %b", tag, j, ctl_obs(), e);
            else pass_cnt++;
            total_cnt++;
            if (ser_data_o !== wd) $display("FAIL %s wait_data[%0d]: got %h want %h", tag, j, ser_data_o, wd);
            else pass_cnt++;
        end
        step();
        e = to ? ctl_exp(1'b1, 1'b0, 1'b1, '0, '0) : ctl_exp(1'b1, 1'b0, 1'b0, g, g);
        total_cnt++;
        if (ctl_obs() !== e) $display("FAIL %s end_ctl: got %b want %b", tag, ctl_obs(), e);
        else pass_cnt++;
        ser_done_i = spur;
        if (!to) req_i = req_i & ~g;
        step();
        ser_done_i = 1'b0;
        e = ctl_exp(1'b0, 1'b0, 1'b0, '0, '0);
        total_cnt++;
        if (ctl_obs() !== e) $display("FAIL %s idle_ctl: got %b want %b", tag, ctl_obs(), e);
        else pass_cnt++;
        total_cnt++;
        if (ser_data_o !== wd) $display("FAIL %s idle_data: got %h want %h", tag, ser_data_o, wd);
        else pass_cnt++;
        m_last = w;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_i = '0; data_i = '0; ser_done_i = 1'b0;
        repeat (2) step();
        total_cnt++;
        if (ctl_obs() !== '0) $display("FAIL reset_ctl: got %b want 0", ctl_obs());
        else pass_cnt++;
        total_cnt++;
        if (ser_data_o !== '0) $display("FAIL reset_data: got %h want 0", ser_data_o);
        else pass_cnt++;
        req_i = '1; data_i = 32'hDEADBEEF;
        step();
        total_cnt++;
        if (ctl_obs() !== '0) $display("FAIL reset_hold_ctl: got %b want 0", ctl_obs());
        else pass_cnt++;
        req_i = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
        m_last = N - 1;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 5; i++)
            do_frame($sformatf("rr%0d", i), 4'b1111, {8'h44, 8'h33, 8'h22, 8'h11}, 3 + i, 1'b0, 1'b0);
        req_i = '0;
    endtask

    task automatic test_single();
        do_frame("single", 4'b0001, {8'h5A, 8'h3C, 8'hC3, 8'hA5}, 9, 1'b0, 1'b0);
        req_i = '0;
    endtask

    task automatic test_timeout();
        do_frame("timeout", 4'b0110, {8'hD4, 8'hC3, 8'hB2, 8'hA1}, 0, 1'b0, 1'b0);
        do_frame("after_timeout", 4'b0110, {8'hD4, 8'hC3, 8'hB2, 8'hA1}, 4, 1'b0, 1'b0);
        req_i = '0;
    endtask

    task automatic test_no_resample();
        do_frame("no_resample", 4'b1000, {8'h96, 8'h69, 8'h0F, 8'hF0}, 5, 1'b1, 1'b1);
        req_i = '0;
    endtask

    task automatic test_coincident();
        do_frame("coincident", 4'b0001, {8'h04, 8'h03, 8'h02, 8'h7E}, TIMEOUT, 1'b0, 1'b0);
        do_frame("near_limit", 4'b0010, {8'h04, 8'h03, 8'h6B, 8'h01}, TIMEOUT - 1, 1'b0, 1'b0);
        req_i = '0;
    endtask

    task automatic test_async_reset();
        req_i = 4'b0100; data_i = {8'h99, 8'h88, 8'h77, 8'h66}; ser_done_i = 1'b0;
        repeat (5) step();
        total_cnt++;
        if (ctl_obs() !== ctl_exp(1'b1, 1'b0, 1'b0, '0, 4'b0100))
            $display("FAIL pre_reset_wait: got %b want %b", ctl_obs(), ctl_exp(1'b1, 1'b0, 1'b0, '0, 4'b0100));
        else pass_cnt++;
        #2 rst_i = 1'b1;
        #1;
        total_cnt++;
        if (ctl_obs() !== '0) $display("FAIL async_reset_ctl: got %b want 0", ctl_obs());
        else pass_cnt++;
        total_cnt++;
        if (ser_data_o !== '0) $display("FAIL async_reset_data: got %h want 0", ser_data_o);
        else pass_cnt++;
        req_i = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
        m_last = N - 1;
        ser_done_i = 1'b1;
        repeat (2) step();
        ser_done_i = 1'b0;
        total_cnt++;
        if (ctl_obs() !== '0) $display("FAIL post_reset_quiet: got %b want 0", ctl_obs());
        else pass_cnt++;
        do_frame("post_reset", 4'b1111, {8'h99, 8'h88, 8'h77, 8'h66}, 2, 1'b0, 1'b0);
        req_i = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] req;
        int dly;
        for (int i = 0; i < 30; i++) begin
            req = N'($urandom_range(1, (1 << N) - 1));
            dly = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
            do_frame($sformatf("rand%0d", i), req, $urandom, dly,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        req_i = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_timeout();
        test_no_resample();
        test_coincident();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
